// File: rtl/pixel_sink_vga.sv
// Pixel-stream sink: FIFO-buffers incoming pixels and plays them out with VGA-style timing.
// Optional macro PIXEL_SINK_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module pixel_sink_vga #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pixel_stream_din,
  input  logic                  pixel_stream_din_valid,
  output logic                  pixel_stream_din_ready,
  output logic [DATA_WIDTH-1:0] video_out_pixel,
  output logic                  video_out_de,
  output logic                  video_out_hsync,
  output logic                  video_out_vsync,
  output logic                  underflow,
  input  logic                  underflow_clr
`ifdef PIXEL_SINK_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]           underflow_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  started;

  logic full, empty, push, pop, active, hs, vs, start_now, running, uf_event;

  assign full   = (count == COUNT_FULL);
  assign empty  = (count == '0);
  assign pixel_stream_din_ready = !full;
  assign push   = pixel_stream_din_valid && !full;

  assign active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Start takes effect in the very cycle it is detected so the first
  // active pixel of the frame already carries the first buffered word.
  assign start_now = !started && (h_cnt == '0) && (v_cnt == '0) && !empty;
  assign running   = started || start_now;
  assign pop       = active && running && !empty;
  assign uf_event  = active && running && empty;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // block sees pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      started <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (start_now) started <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the pointers, so stale contents are never observable.
  always_ff @(posedge pixel_clk) begin
    if (push) mem[wr_ptr] <= pixel_stream_din;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      video_out_de    <= 1'b0;
      video_out_hsync <= 1'b0;
      video_out_vsync <= 1'b0;
      video_out_pixel <= '0;
      underflow       <= 1'b0;
    end else begin
      video_out_de    <= active;
      video_out_hsync <= hs;
      video_out_vsync <= vs;
      video_out_pixel <= pop ? mem[rd_ptr] : '0;
      if (uf_event)           underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

`ifdef PIXEL_SINK_UNDERFLOW_CNT_EN
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_count <= '0;
    end else if (uf_event) begin
      if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
    end else if (underflow_clr) begin
      underflow_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_sink_vga.sv
// Scoreboard bench for pixel_sink_vga using a shrunken video timing so several
// frames fit in a short run; expected outputs come from a frame-position model.
module tb_pixel_sink_vga;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] pixel;
  logic          de, hsync, vsync, uf;
  logic          uf_clr = 1'b0;
`ifdef PIXEL_SINK_UNDERFLOW_CNT_EN
  logic [15:0]   uf_count;
`endif

  always #5 clk = ~clk;

  pixel_sink_vga #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .pixel_clk              (clk),
    .rst_n                  (rst_n),
    .pixel_stream_din       (din),
    .pixel_stream_din_valid (din_valid),
    .pixel_stream_din_ready (din_ready),
    .video_out_pixel        (pixel),
    .video_out_de           (de),
    .video_out_hsync        (hsync),
    .video_out_vsync        (vsync),
    .underflow              (uf),
    .underflow_clr          (uf_clr)
`ifdef PIXEL_SINK_UNDERFLOW_CNT_EN
    ,
    .underflow_count        (uf_count)
`endif
  );

  typedef struct {
    logic          de, hs, vs, uf;
    logic [DW-1:0] pix;
    logic [15:0]   ucnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: frame position, start flag, sticky flag and pixel queue.
  int            m_h, m_v, m_ucnt;
  bit            m_started, m_uf;
  logic [DW-1:0] m_fifo[$];
  int            accepted;
  logic [DW-1:0] next_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_started = 0; m_uf = 0; m_ucnt = 0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_de"},  {31'd0, de},    0);
    check({tag, "_hs"},  {31'd0, hsync}, 0);
    check({tag, "_vs"},  {31'd0, vsync}, 0);
    check({tag, "_pix"}, {24'd0, pixel}, 0);
    check({tag, "_uf"},  {31'd0, uf},    0);
  endtask

  // Called at a falling edge: apply inputs, predict the next rising edge.
  task automatic step(input logic vld, input logic [DW-1:0] d, input logic clr);
    bit   mready, act, pop, ev;
    exp_t e;
    mready = (m_fifo.size() < DEPTH);
    check("ready", {31'd0, din_ready}, {31'd0, mready});
    din_valid = vld; din = d; uf_clr = clr;

    act = (m_h < HA) && (m_v < VA);
    if (!m_started && m_h == 0 && m_v == 0 && m_fifo.size() > 0) m_started = 1;
    pop = act && m_started && m_fifo.size() > 0;
    ev  = act && m_started && m_fifo.size() == 0;

    e.de  = act;
    e.hs  = (m_h >= HA + HFP) && (m_h < HA + HFP + HS);
    e.vs  = (m_v >= VA + VFP) && (m_v < VA + VFP + VS);
    e.pix = pop ? m_fifo[0] : '0;
    if (ev) begin
      m_uf = 1;
      if (m_ucnt < 65535) m_ucnt++;
    end else if (clr) begin
      m_uf = 0;
      m_ucnt = 0;
    end
    e.uf   = m_uf;
    e.ucnt = 16'(m_ucnt);
    exp_q.push_back(e);

    if (pop) void'(m_fifo.pop_front());
    if (vld && mready) begin
      m_fifo.push_back(d);
      accepted++;
    end
    m_h++;
    if (m_h == HT) begin
      m_h = 0;
      m_v = (m_v + 1) % VT;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; din = '0; uf_clr = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_outputs_zero("in_reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compares every produced output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("de",    {31'd0, de},    {31'd0, e.de});
        check("hsync", {31'd0, hsync}, {31'd0, e.hs});
        check("vsync", {31'd0, vsync}, {31'd0, e.vs});
        check("pixel", {24'd0, pixel}, {24'd0, e.pix});
        check("underflow", {31'd0, uf}, {31'd0, e.uf});
`ifdef PIXEL_SINK_UNDERFLOW_CNT_EN
        check("underflow_count", {16'd0, uf_count}, {16'd0, e.ucnt});
`endif
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    check("ready_after_reset", {31'd0, din_ready}, 1);

    // Idle source for one whole frame: timing only, never started.
    repeat (HT * VT) step(1'b0, '0, 1'b0);

    // Fill while display has not started: exactly DEPTH pushes land.
    accepted = 0;
    next_val = '0;
    repeat (HT * VT) begin
      step(1'b1, next_val, 1'b0);
      if (accepted > int'(next_val)) next_val++;
    end
    check("fill_accepted", accepted, DEPTH);
    check("ready_when_full", {31'd0, din_ready}, 0);

    // Streaming counting data for two frames; first de shows pixel 0.
    repeat (2 * HT * VT) begin
      step(1'b1, next_val, 1'b0);
      if (8'(accepted) != next_val) next_val++;
    end

    // Source stops mid-line 3; buffer drains then underflow sticks.
    while (!(m_v == 3 && m_h == HA / 2)) begin
      step(1'b1, next_val, 1'b0);
      if (8'(accepted) != next_val) next_val++;
    end
    while (!(m_v == VA && m_h == 2)) step(1'b0, '0, 1'b0);
    check("underflow_sticky", {31'd0, uf}, 1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("underflow_cleared", {31'd0, uf}, 0);

    // Randomized source traffic with occasional clears.
    repeat (2 * HT * VT)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 39) == 0));

    // Asynchronous reset mid-frame while de is high.
    while (!(m_v == VA / 2 && m_h == HA / 2))
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
    check("de_before_reset", {31'd0, de}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    do_reset();

    // After release: counters restart, FIFO empty, source idle for a frame.
    repeat (HT * VT) step(1'b0, '0, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
